imem_loader: RTL
================

# imem_loader

Boot-time instruction-memory writer that sits beside the pipelined core's instruction memory. The core's fetch stage only reads that memory; this block streams a program in over a byte-wide valid/ready link and writes it as 32-bit words. While loading, it holds the core in reset. It releases the core only after the last word is written.

## Interface
Parameters:
- WIDTH, 32: data word and address width.
- DEPTH, 64: instruction memory capacity in words.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- reset  input  1  asynchronous, active-low reset.
- in_valid  input  1  in_byte carries a valid byte.
- in_byte  input  8  stream byte.
- in_ready  output  1  block can accept a byte this cycle.
- clear  input  1  from DONE or ERR, return to IDLE and re-hold the core.
- we  output  1  instruction-memory write strobe, one cycle per word.
- waddr  output  WIDTH  byte address of the word being written; always a multiple of 4.
- wdata  output  WIDTH  word being written.
- core_rst_n  output  1  active-low reset to the pipeline; 0 while loading.
- busy  output  1  a frame is in progress.
- done  output  1  frame loaded successfully; sticky.
- err  output  1  frame rejected; sticky.

## Operation
- A byte transfers on any cycle where in_valid && in_ready are both high. No other cycle transfers a byte.
- Frame format:
  - 2 header bytes: word count N[15:0], little-endian.
  - Then 4·N data bytes, each word little-endian (the first byte goes to wdata[7:0]).
- States:
  - IDLE: in_ready=1. On a transfer, latch N[7:0] and go to HDR1.
  - HDR1: in_ready=1. On a transfer, latch N[15:8], then evaluate:
    - N>DEPTH goes to ERR.
    - N==0 goes to DONE.
    - Otherwise go to DATA.
  - DATA: in_ready=1. Shift in bytes using a 2-bit byte counter. On the 4th byte, load wdata and go to WRITE.
  - WRITE: in_ready=0 and we=1 for exactly one cycle.
    - Then increment the word index.
    - If the index equals N, go to DONE (or CHK under the macro). Otherwise return to DATA.
  - DONE: in_ready=0, done=1, core_rst_n=1.
  - ERR: in_ready=0, err=1, core_rst_n=0.
- clear in DONE or ERR goes to IDLE and drops done/err/core_rst_n on the next edge. clear is ignored in all other states.
- waddr = word_index·4, and word_index starts at 0 for every frame. N==DEPTH is legal and the last waddr is 4·(DEPTH−1). Wrap-around is impossible because N is bounded by DEPTH.
- busy=1 in HDR1, DATA, WRITE and CHK. busy=0 in IDLE, DONE and ERR.
- Bytes presented while in_ready=0 are not consumed. The source must hold them.
- ERR never issues we. An oversized frame writes nothing.

## Timing
- Reset values:
  - State IDLE, so in_ready=1.
  - we=0, waddr=0, wdata=0.
  - core_rst_n=0, busy=0, done=0, err=0.
  - Byte counter, word index and N all 0.
- Asserting reset mid-frame discards any partial word. Words already written stay in memory. The next frame starts again at waddr 0.
- All outputs are registered, except in_ready, which is decoded from the state.
- Write latency: we rises on the cycle after the 4th byte of a word transfers. wdata and waddr are stable while we=1.
- Peak throughput is one word per 5 cycles (4 byte cycles plus the WRITE cycle).
- done and core_rst_n rise on the cycle after the final WRITE cycle. For N==0, they rise on the cycle after the 2nd header byte.

## Configuration
- IMEM_LOADER_CHECKSUM_EN defined:
  - One extra byte follows the data: the XOR of all 4·N data bytes. The accumulator resets at IDLE.
  - A CHK state (in_ready=1) accepts that byte. A match goes to DONE; a mismatch goes to ERR.
  - For N==0, the checksum byte 0x00 is still required.
- Undefined: no CHK state. The frame ends after the last WRITE.

## Test plan
- Frame 02 00, 13 00 00 00, 93 00 10 00 sent back-to-back → two we pulses: (waddr 0, wdata 0x00000013) and (waddr 4, wdata 0x00100093). Then done=1 and core_rst_n=1, and they stay high.
- Frame 00 00 → no we; done=1 on the cycle after the 2nd byte. With the macro, done waits for checksum byte 0x00.
- With DEPTH=64, header 41 00 → err=1, in_ready=0, core_rst_n=0, and no we. Then clear=1 → IDLE with err=0.
- Random in_valid gaps, with in_valid held high through every WRITE cycle → wdata sequence identical to the gap-free run, and no byte is lost or duplicated.
- Drive reset=0 after the 2nd data byte of word 1 → all outputs at reset values. A new 1-word frame then writes waddr 0.
- With the macro: frame 01 00, 13 00 00 00, checksum 0x13 → done=1. Checksum 0x12 → err=1, core_rst_n=0.

Source files
------------

// File: rtl/imem_loader.sv
// imem_loader
//   Boot-time instruction-memory writer. Receives a framed program over a
//   byte-wide valid/ready link and writes it into instruction memory as
//   little-endian 32-bit words, holding the core in reset until the whole
//   frame has been written.
//
//   Frame: N[7:0], N[15:8], then 4*N data bytes (each word LSB first).
//   Optional build macro IMEM_LOADER_CHECKSUM_EN: one trailing byte equal to
//   the XOR of all data bytes, checked in a CHK state before DONE.
//
// Ports
//   clk         system clock, rising edge
//   reset       asynchronous active-low reset
//   in_valid    in_byte carries a valid byte
//   in_byte     stream byte
//   in_ready    loader can accept a byte this cycle (decoded from state)
//   clear       from DONE/ERR: return to IDLE and re-hold the core
//   we          instruction-memory write strobe, one cycle per word
//   waddr       byte address of the word being written (multiple of 4)
//   wdata       word being written
//   core_rst_n  active-low reset to the pipeline, released only in DONE
//   busy        a frame is in progress
//   done        frame loaded successfully (sticky until clear)
//   err         frame rejected (sticky until clear)
module imem_loader #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 64
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    input  logic [7:0]       in_byte,
    output logic             in_ready,
    input  logic             clear,
    output logic             we,
    output logic [WIDTH-1:0] waddr,
    output logic [WIDTH-1:0] wdata,
    output logic             core_rst_n,
    output logic             busy,
    output logic             done,
    output logic             err
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_HDR1,
        S_DATA,
        S_WRITE,
        S_DONE,
        S_ERR
`ifdef IMEM_LOADER_CHECKSUM_EN
        , S_CHK
`endif
    } state_t;

    // State entered once all data words have been written.
`ifdef IMEM_LOADER_CHECKSUM_EN
    localparam state_t S_END = S_CHK;
`else
    localparam state_t S_END = S_DONE;
`endif

    state_t      state;
    state_t      state_next;
    logic [15:0] n;
    logic [15:0] hdr_n;
    logic [15:0] word_idx;
    logic [1:0]  byte_cnt;
    logic [7:0]  b0;
    logic [7:0]  b1;
    logic [7:0]  b2;
    logic        xfer;
    logic        last_word;
`ifdef IMEM_LOADER_CHECKSUM_EN
    logic [7:0]  csum;
`endif

    always_comb begin
        in_ready = (state == S_IDLE) || (state == S_HDR1) || (state == S_DATA);
`ifdef IMEM_LOADER_CHECKSUM_EN
        if (state == S_CHK) in_ready = 1'b1;
`endif
    end

    assign xfer      = in_valid && in_ready;
    // Full word count as it becomes known on the second header byte.
    assign hdr_n     = {in_byte, n[7:0]};
    assign last_word = (word_idx + 16'd1) == n;

    always_comb begin
        state_next = state;
        case (state)
            S_IDLE:  if (xfer) state_next = S_HDR1;
            S_HDR1: begin
                if (xfer) begin
                    if ({16'd0, hdr_n} > 32'(DEPTH)) state_next = S_ERR;
                    else if (hdr_n == 16'd0)         state_next = S_END;
                    else                             state_next = S_DATA;
                end
            end
            S_DATA:  if (xfer && byte_cnt == 2'd3) state_next = S_WRITE;
            S_WRITE: state_next = last_word ? S_END : S_DATA;
            S_DONE:  if (clear) state_next = S_IDLE;
            S_ERR:   if (clear) state_next = S_IDLE;
`ifdef IMEM_LOADER_CHECKSUM_EN
            S_CHK:   if (xfer) state_next = (in_byte == csum) ? S_DONE : S_ERR;
`endif
            default: state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= S_IDLE;
            n          <= '0;
            word_idx   <= '0;
            byte_cnt   <= '0;
            b0         <= '0;
            b1         <= '0;
            b2         <= '0;
            we         <= 1'b0;
            waddr      <= '0;
            wdata      <= '0;
            core_rst_n <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
            err        <= 1'b0;
`ifdef IMEM_LOADER_CHECKSUM_EN
            csum       <= '0;
`endif
        end else begin
            state <= state_next;
            // Status outputs are registered decodes of the next state so they
            // change on the same edge as the state itself.
            we         <= (state_next == S_WRITE);
            done       <= (state_next == S_DONE);
            err        <= (state_next == S_ERR);
            core_rst_n <= (state_next == S_DONE);
            busy       <= (state_next == S_HDR1) || (state_next == S_DATA) ||
                          (state_next == S_WRITE)
`ifdef IMEM_LOADER_CHECKSUM_EN
                          || (state_next == S_CHK)
`endif
                          ;
            case (state)
                S_IDLE: begin
                    word_idx <= '0;
                    byte_cnt <= '0;
`ifdef IMEM_LOADER_CHECKSUM_EN
                    csum     <= '0;
`endif
                    if (xfer) n <= {8'h00, in_byte};
                end
                S_HDR1: begin
                    if (xfer) n[15:8] <= in_byte;
                end
                S_DATA: begin
                    if (xfer) begin
                        byte_cnt <= byte_cnt + 2'd1;
`ifdef IMEM_LOADER_CHECKSUM_EN
                        csum     <= csum ^ in_byte;
`endif
                        case (byte_cnt)
                            2'd0: b0 <= in_byte;
                            2'd1: b1 <= in_byte;
                            2'd2: b2 <= in_byte;
                            default: begin
                                wdata <= WIDTH'({in_byte, b2, b1, b0});
                                waddr <= WIDTH'({word_idx, 2'b00});
                            end
                        endcase
                    end
                end
                S_WRITE: word_idx <= word_idx + 16'd1;
                default: ;
            endcase
        end
    end

endmodule
